// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the single-outstanding AXI4-lite initiator.
// FSM state encoding, response codes and default bus widths.
package axi4_lite_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StResp
  } state_e;

  // States in which the initiator is waiting on the slave and the timer runs.
  function automatic logic is_wait_state(input state_e st);
    return (st == StWrReq) || (st == StWrResp) || (st == StRdReq) || (st == StRdData);
  endfunction

endpackage

// File: rtl/axi_wait_timer.sv
// Saturating wait-cycle counter: clears on demand, counts while enabled,
// flags expiry once the count reaches Limit.
module axi_wait_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] count_q;

  assign expired_o = (count_q == CntW'(Limit));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-lite initiator: one local command in, one AW/W/B or
// AR/R transaction out, one response back, with a per-state wait timeout.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET_N,
  // Local command / response
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic [1:0]        RSP_RESP,
  output logic              RSP_TIMEOUT,
  // Write address / data / response
  output logic [ADDR_W-1:0] A_W_ADDR,
  output logic              A_W_VALID,
  input  logic              A_W_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY,
  // Read address / data
  output logic [ADDR_W-1:0] A_R_ADDR,
  output logic              A_R_VALID,
  input  logic              A_R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic              R_VALID,
  input  logic              R_RESP,
  output logic              R_READY
);

  state_e state_q;
  logic   aw_done_q, w_done_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_both_done;
  logic hs_done;
  logic timer_en, timer_clr, timer_expired;
  logic abort;

  assign CMD_READY = (state_q == StIdle);

  assign aw_hs = A_W_VALID && A_W_READY;
  assign w_hs  = W_VALID && W_READY;
  assign b_hs  = B_VALID && B_READY;
  assign ar_hs = A_R_VALID && A_R_READY;
  assign r_hs  = R_VALID && R_READY;

  assign wr_both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // The handshake that ends the current wait state; it takes priority over expiry.
  always_comb begin
    hs_done = 1'b0;
    unique case (state_q)
      StWrReq:  hs_done = wr_both_done;
      StWrResp: hs_done = b_hs;
      StRdReq:  hs_done = ar_hs;
      StRdData: hs_done = r_hs;
      default:  hs_done = 1'b0;
    endcase
  end

  assign timer_en  = is_wait_state(state_q);
  assign timer_clr = !timer_en || hs_done;
  assign abort     = timer_en && timer_expired && !hs_done;

  axi_wait_timer #(
    .Limit (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (CLK),
    .rst_ni    (RESET_N),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      A_W_ADDR    <= '0;
      A_W_VALID   <= 1'b0;
      W_DATA      <= '0;
      W_VALID     <= 1'b0;
      B_READY     <= 1'b0;
      A_R_ADDR    <= '0;
      A_R_VALID   <= 1'b0;
      R_READY     <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_RESP    <= RESP_OKAY;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (CMD_VALID && CMD_READY) begin
            if (CMD_WRITE) begin
              A_W_ADDR  <= CMD_ADDR;
              W_DATA    <= CMD_WDATA;
              A_W_VALID <= 1'b1;
              W_VALID   <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= StWrReq;
            end else begin
              A_R_ADDR  <= CMD_ADDR;
              A_R_VALID <= 1'b1;
              state_q   <= StRdReq;
            end
          end
        end

        StWrReq: begin
          if (aw_hs) begin
            A_W_VALID <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            W_VALID  <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (wr_both_done) begin
            B_READY <= 1'b1;
            state_q <= StWrResp;
          end
        end

        StWrResp: begin
          if (b_hs) begin
            RSP_RESP  <= B_RESP;
            B_READY   <= 1'b0;
            RSP_VALID <= 1'b1;
            state_q   <= StResp;
          end
        end

        StRdReq: begin
          if (ar_hs) begin
            A_R_VALID <= 1'b0;
            R_READY   <= 1'b1;
            state_q   <= StRdData;
          end
        end

        StRdData: begin
          if (r_hs) begin
            RSP_RDATA <= R_DATA;
            RSP_RESP  <= {1'b0, R_RESP};
            R_READY   <= 1'b0;
            RSP_VALID <= 1'b1;
            state_q   <= StResp;
          end
        end

        StResp: begin
          RSP_TIMEOUT <= 1'b0;
          state_q     <= StIdle;
        end

        default: state_q <= StIdle;
      endcase

      // Debug-recovery abort: abandons the slave mid-handshake.
      if (abort) begin
        A_W_VALID   <= 1'b0;
        W_VALID     <= 1'b0;
        B_READY     <= 1'b0;
        A_R_VALID   <= 1'b0;
        R_READY     <= 1'b0;
        RSP_RESP    <= RESP_SLVERR;
        RSP_TIMEOUT <= 1'b1;
        RSP_VALID   <= 1'b1;
        state_q     <= StResp;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: reactive slave model with a
// scoreboard of expected responses, a vector table and corner-case sequences.
module tb_axi4_lite_master;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [4:0]  CMD_ADDR;
  logic [15:0] CMD_WDATA;
  logic        RSP_VALID, RSP_TIMEOUT;
  logic [15:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [4:0]  A_W_ADDR, A_R_ADDR;
  logic        A_W_VALID, A_W_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [15:0] W_DATA, R_DATA;
  logic [1:0]  B_RESP;
  logic        A_R_VALID, A_R_READY, R_VALID, R_RESP, R_READY;

  axi4_lite_master #(
    .ADDR_W         (5),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_WRITE   (CMD_WRITE),
    .CMD_ADDR    (CMD_ADDR),
    .CMD_WDATA   (CMD_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_RESP    (RSP_RESP),
    .RSP_TIMEOUT (RSP_TIMEOUT),
    .A_W_ADDR    (A_W_ADDR),
    .A_W_VALID   (A_W_VALID),
    .A_W_READY   (A_W_READY),
    .W_DATA      (W_DATA),
    .W_VALID     (W_VALID),
    .W_READY     (W_READY),
    .B_VALID     (B_VALID),
    .B_RESP      (B_RESP),
    .B_READY     (B_READY),
    .A_R_ADDR    (A_R_ADDR),
    .A_R_VALID   (A_R_VALID),
    .A_R_READY   (A_R_READY),
    .R_DATA      (R_DATA),
    .R_VALID     (R_VALID),
    .R_RESP      (R_RESP),
    .R_READY     (R_READY)
  );

  always #5 CLK = ~CLK;

  // ---------------- slave model ----------------
  int          sl_aw_lat = 0, sl_w_lat = 0;
  logic        sl_ben = 1'b1, sl_ren = 1'b1;
  logic [1:0]  sl_bresp = 2'b00;
  logic        sl_rresp = 1'b0;
  int          aw_wait, w_wait, aw_hs_cnt = 0;
  logic        aw_got, w_got, ar_got;
  logic [4:0]  aw_a, ar_a;
  logic [15:0] w_d;
  logic [15:0] mem [32];

  assign A_W_READY = A_W_VALID && (aw_wait >= sl_aw_lat);
  assign W_READY   = W_VALID && (w_wait >= sl_w_lat);
  assign B_VALID   = sl_ben && aw_got && w_got;
  assign B_RESP    = sl_bresp;
  assign A_R_READY = A_R_VALID;
  assign R_VALID   = sl_ren && ar_got;
  assign R_DATA    = ar_got ? mem[ar_a] : 16'h0000;
  assign R_RESP    = sl_rresp;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      aw_wait <= 0;
      w_wait  <= 0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      ar_got  <= 1'b0;
      aw_a    <= '0;
      ar_a    <= '0;
      w_d     <= '0;
    end else begin
      aw_wait <= (A_W_VALID && !A_W_READY) ? aw_wait + 1 : 0;
      w_wait  <= (W_VALID && !W_READY) ? w_wait + 1 : 0;
      if (A_W_VALID && A_W_READY) begin
        aw_got <= 1'b1;
        aw_a   <= A_W_ADDR;
      end
      if (W_VALID && W_READY) begin
        w_got <= 1'b1;
        w_d   <= W_DATA;
      end
      if (B_VALID && B_READY) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (A_R_VALID && A_R_READY) begin
        ar_got <= 1'b1;
        ar_a   <= A_R_ADDR;
      end
      if (R_VALID && R_READY) ar_got <= 1'b0;
    end
  end

  always @(posedge CLK) begin
    if (RESET_N && B_VALID && B_READY) mem[aw_a] <= w_d;
    if (RESET_N && A_W_VALID && A_W_READY) aw_hs_cnt <= aw_hs_cnt + 1;
  end

  // VALID must stay high with a stable payload until its READY is seen.
  int          w_viol = 0, aw_viol = 0;
  logic        w_hold = 1'b0, aw_hold = 1'b0;
  logic [15:0] w_hold_d;
  logic [4:0]  aw_hold_a;
  always @(posedge CLK) begin
    if (RESET_N) begin
      if (w_hold && (!W_VALID || W_DATA != w_hold_d)) w_viol <= w_viol + 1;
      if (aw_hold && (!A_W_VALID || A_W_ADDR != aw_hold_a)) aw_viol <= aw_viol + 1;
    end
    w_hold    <= RESET_N && W_VALID && !W_READY;
    w_hold_d  <= W_DATA;
    aw_hold   <= RESET_N && A_W_VALID && !A_W_READY;
    aw_hold_a <= A_W_ADDR;
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0, n_cmd = 0, n_rsp = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [1:0]  resp;
    logic        tmo;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  bresp;
    logic        rresp;
    logic [1:0]  exp_resp;
    logic [15:0] exp_rdata;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge CLK) begin
    if (RESET_N && RSP_VALID) begin
      n_rsp++;
      check("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_resp", RSP_RESP, mon_e.resp);
        check("rsp_timeout", RSP_TIMEOUT, mon_e.tmo);
        check("rsp_rdata", RSP_RDATA, mon_e.rdata);
      end
    end
  end

  // Returns at the negedge where RSP_VALID is seen. lat counts the accept cycle as 1.
  task automatic wait_rsp(output int lat);
    lat = 2;
    while (!RSP_VALID && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    check("rsp_seen", RSP_VALID, 1);
  endtask

  task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [15:0] d,
                        input exp_t e, output int lat);
    @(negedge CLK);
    CMD_WRITE = wr;
    CMD_ADDR  = a;
    CMD_WDATA = d;
    CMD_VALID = 1'b1;
    for (int i = 0; i < 50 && !CMD_READY; i++) @(negedge CLK);
    exp_q.push_back(e);
    n_cmd++;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    wait_rsp(lat);
  endtask

  vec_t vecs[8];
  exp_t e;
  int   lat, aw0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;

    vecs[0] = '{1'b1, 5'd3,  16'hA5A5, 2'b00, 1'b0, 2'b00, 16'h0000};
    vecs[1] = '{1'b0, 5'd3,  16'h0000, 2'b00, 1'b0, 2'b00, 16'hA5A5};
    vecs[2] = '{1'b1, 5'd31, 16'h1234, 2'b00, 1'b0, 2'b00, 16'hA5A5};
    vecs[3] = '{1'b0, 5'd31, 16'h0000, 2'b00, 1'b0, 2'b00, 16'h1234};
    vecs[4] = '{1'b1, 5'd7,  16'hBEEF, 2'b01, 1'b0, 2'b01, 16'h1234};
    vecs[5] = '{1'b0, 5'd7,  16'h0000, 2'b00, 1'b1, 2'b01, 16'hBEEF};
    vecs[6] = '{1'b1, 5'd0,  16'h0001, 2'b11, 1'b0, 2'b11, 16'hBEEF};
    vecs[7] = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b0, 2'b00, 16'h0001};

    // Reset state
    #12;
    check("rst_flags", {CMD_READY, A_W_VALID, W_VALID, B_READY, A_R_VALID, R_READY,
                        RSP_VALID, RSP_TIMEOUT}, 8'h80);
    check("rst_data", {RSP_RESP, RSP_RDATA, A_W_ADDR, W_DATA, A_R_ADDR}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Vector table with a fast slave: minimum latency everywhere.
    for (int i = 0; i < 8; i++) begin
      sl_bresp = vecs[i].bresp;
      sl_rresp = vecs[i].rresp;
      e = '{vecs[i].exp_resp, 1'b0, vecs[i].exp_rdata};
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, e, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy_in_resp", i), CMD_READY, 0);
    end
    sl_bresp = 2'b00;
    sl_rresp = 1'b0;

    // W_READY three cycles after A_W_READY.
    sl_w_lat = 3;
    aw0 = aw_hs_cnt;
    do_cmd(1'b1, 5'd9, 16'h5A5A, '{2'b00, 1'b0, 16'h0001}, lat);
    check("wdly_latency", lat, 7);
    check("wdly_aw_beats", aw_hs_cnt - aw0, 1);
    check("wdly_w_stable", w_viol, 0);
    check("wdly_aw_stable", aw_viol, 0);
    sl_w_lat = 0;

    // Slave never answers B: timeout abort.
    sl_ben = 1'b0;
    do_cmd(1'b1, 5'd10, 16'h7777, '{2'b10, 1'b1, 16'h0001}, lat);
    check("tmo_latency_range", (lat >= 10) && (lat <= 14), 1);
    check("tmo_bready_low", B_READY, 0);
    @(negedge CLK);
    check("tmo_cmd_ready_next", CMD_READY, 1);
    check("tmo_flag_cleared", RSP_TIMEOUT, 0);
    check("tmo_bready_after", B_READY, 0);

    // Reset while waiting in the read-data state.
    sl_ren = 1'b0;
    @(negedge CLK);
    CMD_WRITE = 1'b0;
    CMD_ADDR  = 5'd31;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check("rst_mid_rready_before", R_READY, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_mid_async", {A_R_VALID, R_READY, RSP_VALID, CMD_READY}, 4'b0001);
    @(negedge CLK);
    @(negedge CLK);
    check("rst_mid_rdata_cleared", RSP_RDATA, 0);
    RESET_N = 1'b1;
    sl_ren  = 1'b1;
    sl_ben  = 1'b1;
    do_cmd(1'b0, 5'd31, 16'h0000, '{2'b00, 1'b0, 16'h1234}, lat);
    check("rst_read31_latency", lat, 4);

    // Back-to-back with CMD_VALID held high through the first transaction.
    @(negedge CLK);
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 5'd12;
    CMD_WDATA = 16'hC0DE;
    CMD_VALID = 1'b1;
    exp_q.push_back('{2'b00, 1'b0, 16'h1234});
    n_cmd++;
    @(negedge CLK);
    wait_rsp(lat);
    check("b2b_first_latency", lat, 4);
    check("b2b_busy_in_resp", CMD_READY, 0);
    CMD_WRITE = 1'b0;
    exp_q.push_back('{2'b00, 1'b0, 16'hC0DE});
    n_cmd++;
    @(negedge CLK);
    check("b2b_ready_after_resp", CMD_READY, 1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    wait_rsp(lat);

    repeat (4) @(negedge CLK);
    check("one_rsp_per_cmd", n_rsp, n_cmd);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
